// File: rtl/data_bus_bridge_pkg.sv
// Shared constants and types for the data-bus bridge: FSM encoding, error read
// data default and the latched request record.
package data_bus_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;
  localparam logic [31:0] ZERO = 32'h0;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_bus_bridge_if.sv
// Registered req/ack memory-side bus of the data-bus bridge.
interface data_bus_bridge_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/data_bus_bridge_wait_counter.sv
// Saturating 16-bit wait counter with terminal-count flag for the bus timeout.
module data_bus_bridge_wait_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = 16'h0;
    else if (en_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= 16'h0;
    else         cnt_q <= cnt_d;

  // Fires in the WAIT cycle whose increment reaches TIMEOUT_CYCLES.
  assign tc_o = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);
endmodule

// File: rtl/data_bus_bridge.sv
// Bridges a zero-wait datapath data port onto a registered req/ack memory bus,
// stalling the core until completion. Define DATA_BUS_TIMEOUT_EN for bus timeout.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iReadEnable,
  input  logic                       iWriteEnable,
  input  logic [3:0]                 iByteEnable,
  input  logic [31:0]                iAddress,
  input  logic [31:0]                iWriteData,
  output logic [31:0]                oReadData,
  output logic                       oStall,
  data_bus_bridge_if.master          mem,
  output logic                       oBusError
);
  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  mem_req_t    lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cnt_clr, cnt_en, tc, timeout;
  logic        req;

  assign req = iReadEnable | iWriteEnable;

  data_bus_bridge_wait_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_cnt (
    .clk_i  (iCLK),
    .rst_ni (iRST),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (tc)
  );

`ifdef DATA_BUS_TIMEOUT_EN
  assign timeout = tc;
`else
  logic unused_tc;
  assign unused_tc = tc;
  assign timeout   = OFF;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_clr = OFF;
    cnt_en  = OFF;
    case (state_q)
      ST_IDLE: if (req) begin
        lat_d.we    = iWriteEnable;
        lat_d.be    = iWriteEnable ? iByteEnable : 4'b1111;
        lat_d.addr  = iAddress;
        lat_d.wdata = iWriteData;
        req_d       = ON;
        cnt_clr     = ON;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = ON;
        // Ack beats a coincident timeout.
        if (mem.ack) begin
          if (!lat_q.we) rdata_d = mem.rdata;
          req_d   = OFF;
          state_d = ST_DONE;
        end else if (timeout) begin
          rdata_d = ERR_RDATA;
          err_d   = ON;
          req_d   = OFF;
          state_d = ST_DONE;
        end
      end
      // Leave DONE regardless of req so the committed access is not replayed.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q <= ST_IDLE;
      req_q   <= OFF;
      lat_q   <= '0;
      rdata_q <= ZERO;
      err_q   <= OFF;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end

  // No stall while reset is held: the core is being reset with us.
  assign oStall    = iRST & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));
  assign oReadData = rdata_q;
  assign oBusError = err_q;

  assign mem.req   = req_q;
  assign mem.we    = lat_q.we;
  assign mem.be    = lat_q.be;
  assign mem.addr  = lat_q.addr;
  assign mem.wdata = lat_q.wdata;
endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge; timeout cases run only when
// DATA_BUS_TIMEOUT_EN is defined.
module tb_data_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o;
  logic        stall, bus_err;
  int          checks = 0, errors = 0;
  int          stall_cnt = 0, req_rise = 0;
  logic        req_prev = 1'b0;
  logic [31:0] exp_rd = 32'h0;

  data_bus_bridge_if mem_if();

  data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .iCLK(clk), .iRST(rst_n), .iReadEnable(rd), .iWriteEnable(wr),
    .iByteEnable(be), .iAddress(addr), .iWriteData(wdata),
    .oReadData(rdata_o), .oStall(stall), .mem(mem_if), .oBusError(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stall) stall_cnt <= stall_cnt + 1;
    if (mem_if.req && !req_prev) req_rise <= req_rise + 1;
    req_prev <= mem_if.req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Starts in IDLE; ack arrives after `waits` empty WAIT cycles; ends in DONE.
  task automatic access(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] mrd,
                        input bit scramble, input bit drop);
    int s0;
    logic [3:0] exp_be;
    logic we;
    s0 = stall_cnt;
    we = w;
    exp_be = w ? b : 4'b1111;
    rd = r; wr = w; be = b; addr = a; wdata = d;
    #1 chk("stall_idle_req", {31'b0, stall}, 32'd1);
    step();
    for (int i = 0; i <= waits; i++) begin
      chk("req_wait", {31'b0, mem_if.req}, 32'd1);
      chk("we_held", {31'b0, mem_if.we}, {31'b0, we});
      chk("be_held", {28'b0, mem_if.be}, {28'b0, exp_be});
      chk("addr_held", mem_if.addr, a);
      chk("wdata_held", mem_if.wdata, d);
      if (scramble) begin
        rd = 1'($urandom); be = 4'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      if (i == waits) begin
        mem_if.ack = 1'b1; mem_if.rdata = mrd;
      end
      step();
    end
    mem_if.ack = 1'b0; mem_if.rdata = 32'h0;
    if (!we) exp_rd = mrd;
    if (scramble) begin
      rd = r; wr = w;
    end
    chk("stall_done", {31'b0, stall}, 32'd0);
    chk("req_done", {31'b0, mem_if.req}, 32'd0);
    chk("rdata_done", rdata_o, exp_rd);
    chk("stall_cycles", stall_cnt - s0, waits + 2);
    if (drop) begin
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  initial begin
    int r0;
    rd = 0; wr = 0; be = 0; addr = 0; wdata = 0;
    mem_if.ack = 0; mem_if.rdata = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_req", {31'b0, mem_if.req}, 32'd0);
    chk("rst_be", {28'b0, mem_if.be}, 32'd0);
    chk("rst_addr", mem_if.addr, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    step();

    // read, ack in first WAIT cycle
    access(1, 0, 4'b0000, 32'h1001_0004, 32'h0, 0, 32'h1234_5678, 0, 1);
    step();
    chk("idle_no_stall", {31'b0, stall}, 32'd0);

    // write, 5 wait cycles, inputs scrambled in WAIT
    access(0, 1, 4'b0011, 32'h1001_0040, 32'hCAFE_BABE, 5, 32'h5555_AAAA, 1, 1);
    step();

    // back-to-back loads: exactly two requests
    r0 = req_rise;
    access(1, 0, 4'b0, 32'h0000_0100, 32'h0, 1, 32'h0000_0A0A, 0, 0);
    step();
    access(1, 0, 4'b0, 32'h0000_0104, 32'h0, 0, 32'h0000_0B0B, 0, 1);
    step();
    step();
    chk("b2b_req_count", req_rise - r0, 32'd2);

    // reset pulsed during WAIT, late ack ignored
    rd = 1; addr = 32'h2000_0000;
    step();
    chk("pre_rst_req", {31'b0, mem_if.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, mem_if.req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    rd = 0;
    #2 rst_n = 1'b1;
    exp_rd = 32'h0;
    step();
    mem_if.ack = 1'b1; mem_if.rdata = 32'hBAD0_BAD0;
    step();
    mem_if.ack = 1'b0;
    step();
    chk("late_ack_req", {31'b0, mem_if.req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall}, 32'd0);
    chk("late_ack_rdata", rdata_o, 32'h0);

    // both enables -> write
    access(1, 1, 4'b0101, 32'h3000_0008, 32'h0BAD_F00D, 0, 32'h7777_7777, 0, 1);
    step();
    // spurious ack in IDLE with req=0
    mem_if.ack = 1'b1; mem_if.rdata = 32'h1111_2222;
    step();
    mem_if.ack = 1'b0;
    chk("spur_req", {31'b0, mem_if.req}, 32'd0);
    chk("spur_stall", {31'b0, stall}, 32'd0);
    step();
    chk("spur_req2", {31'b0, mem_if.req}, 32'd0);
    chk("spur_rdata", rdata_o, exp_rd);
    chk("no_err", {31'b0, bus_err}, 32'd0);

`ifdef DATA_BUS_TIMEOUT_EN
    // timeout after 4 WAIT cycles, no ack
    rd = 1; addr = 32'h4000_0000;
    step();
    repeat (3) step();
    chk("to_still_wait", {31'b0, stall}, 32'd1);
    rd = 0;
    step();
    chk("to_done_stall", {31'b0, stall}, 32'd0);
    chk("to_rdata", rdata_o, 32'hDEADBEEF);
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_req", {31'b0, mem_if.req}, 32'd0);
    repeat (3) step();
    chk("to_err_sticky", {31'b0, bus_err}, 32'd1);
    rst_n = 1'b0; #3 rst_n = 1'b1;
    exp_rd = 32'h0;
    step();
    // ack in the 4th WAIT cycle wins
    access(1, 0, 4'b0, 32'h4000_0004, 32'h0, 3, 32'h600D_DA7A, 0, 1);
    chk("to_ack_err", {31'b0, bus_err}, 32'd0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
